// File: rtl/ps2_pkg.sv
// Shared scan-code constants, decoder state and event types for the PS/2 key decoder.
package ps2_pkg;

  // Prefix and housekeeping bytes sent by the keyboard.
  localparam logic [7:0] SC_EXT = 8'hE0;
  localparam logic [7:0] SC_BRK = 8'hF0;
  localparam logic [7:0] SC_ACK = 8'hFA;
  localparam logic [7:0] SC_BAT = 8'hAA;

  // Arrow keys (E0-prefixed).
  localparam logic [7:0] SC_ARROW_UP    = 8'h75;
  localparam logic [7:0] SC_ARROW_DOWN  = 8'h72;
  localparam logic [7:0] SC_ARROW_LEFT  = 8'h6B;
  localparam logic [7:0] SC_ARROW_RIGHT = 8'h74;

  // WASD aliases (non-extended).
  localparam logic [7:0] SC_W = 8'h1D;
  localparam logic [7:0] SC_S = 8'h1B;
  localparam logic [7:0] SC_A = 8'h1C;
  localparam logic [7:0] SC_D = 8'h23;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_E0   = 2'd1,
    ST_F0   = 2'd2,
    ST_E0F0 = 2'd3
  } dec_state_e;

  // Direction encoding doubles as the bit index into held.
  typedef enum logic [1:0] {
    DIR_UP    = 2'd0,
    DIR_DOWN  = 2'd1,
    DIR_LEFT  = 2'd2,
    DIR_RIGHT = 2'd3
  } dir_e;

  localparam int unsigned DIR_N = 4;

  typedef struct packed {
    logic       ext;
    logic       brk;
    logic [7:0] code;
  } key_evt_t;

  localparam int unsigned EVT_W = $bits(key_evt_t);

  typedef struct packed {
    logic hit;
    dir_e idx;
  } dir_hit_t;

  // Map a decoded event to a game direction, if it is one.
  function automatic dir_hit_t dir_decode(input key_evt_t e, input logic wasd_en);
    dir_hit_t r;
    r.hit = 1'b0;
    r.idx = DIR_UP;
    if (e.ext) begin
      case (e.code)
        SC_ARROW_UP:    begin r.hit = 1'b1; r.idx = DIR_UP;    end
        SC_ARROW_DOWN:  begin r.hit = 1'b1; r.idx = DIR_DOWN;  end
        SC_ARROW_LEFT:  begin r.hit = 1'b1; r.idx = DIR_LEFT;  end
        SC_ARROW_RIGHT: begin r.hit = 1'b1; r.idx = DIR_RIGHT; end
        default: ;
      endcase
    end else if (wasd_en) begin
      case (e.code)
        SC_W: begin r.hit = 1'b1; r.idx = DIR_UP;    end
        SC_S: begin r.hit = 1'b1; r.idx = DIR_DOWN;  end
        SC_A: begin r.hit = 1'b1; r.idx = DIR_LEFT;  end
        SC_D: begin r.hit = 1'b1; r.idx = DIR_RIGHT; end
        default: ;
      endcase
    end
    return r;
  endfunction

  // Highest-priority held direction: UP > DOWN > LEFT > RIGHT.
  function automatic dir_e first_held(input logic [DIR_N-1:0] h);
    dir_e r;
    logic found;
    logic [1:0] idx;
    r     = DIR_UP;
    found = 1'b0;
    for (int unsigned i = 0; i < DIR_N; i++) begin
      idx = i[1:0];
      if (h[i] && !found) begin
        r     = dir_e'(idx);
        found = 1'b1;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/ps2_key_decoder_if.sv
// Decoded key-event stream: valid/ready handshake carrying the FIFO head event.
interface ps2_key_decoder_if;
  logic       evt_valid;
  logic       evt_ready;
  logic [7:0] evt_code;
  logic       evt_ext;
  logic       evt_break;

  modport master (
    output evt_valid, evt_code, evt_ext, evt_break,
    input  evt_ready
  );

  modport slave (
    input  evt_valid, evt_code, evt_ext, evt_break,
    output evt_ready
  );
endinterface

// File: rtl/ps2_key_decoder_sync_fifo.sv
// First-word-fall-through synchronous FIFO; head word reads as zero while empty.
module sync_fifo #(
  parameter int unsigned WIDTH = 10,
  parameter int unsigned DEPTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_q, wr_d, rd_q, rd_d;
  logic [AW:0]      cnt_q, cnt_d;
  logic             do_push, do_pop;

  assign full_o  = (cnt_q == FULL_CNT);
  assign empty_o = (cnt_q == '0);
  assign do_pop  = pop_i && !empty_o;
  // A pop in the same cycle frees the slot a full FIFO needs for the push.
  assign do_push = push_i && (!full_o || do_pop);
  assign data_o  = empty_o ? '0 : mem_q[rd_q];

  // Next pointer/occupancy values; pointers wrap naturally (DEPTH is a power of two).
  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (do_push) wr_d = wr_q + 1'b1;
    if (do_pop)  rd_d = rd_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  // Storage array; contents are never observed while empty, so no reset.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_q] <= data_i;
  end

endmodule

// File: rtl/ps2_key_decoder.sv
// PS/2 scan-code decoder: prefix FSM with idle timeout, direction tracking and event FIFO.
module ps2_key_decoder
  import ps2_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH     = 8,
  parameter int unsigned TIMEOUT_CYCLES = 500000,
  parameter bit          WASD_EN        = 1'b1
) (
  input  logic               clock,
  input  logic               resetn,
  input  logic [7:0]         key_data,
  input  logic               key_strobe,
  ps2_key_decoder_if.master  evt,
  input  logic               overflow_clr,
  output logic               overflow,
  output logic [3:0]         held,
  output logic [1:0]         dir,
  output logic               dir_valid
);

  localparam int unsigned TO_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  dec_state_e       state_q, state_d;
  logic [TO_W-1:0]  to_cnt_q, to_cnt_d;
  logic             timeout;

  key_evt_t         evt_new;
  logic             evt_push;
  key_evt_t         evt_head;
  logic             fifo_full, fifo_empty, fifo_pop;

  logic [DIR_N-1:0] held_q, held_d;
  dir_e             dir_q, dir_d;
  dir_hit_t         hit;
  logic             overflow_q, overflow_d;

  assign timeout = (state_q != ST_IDLE) && !key_strobe && (to_cnt_q == TO_LAST);

  // Decoder state register.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  // Next state: advances only on a strobe, or falls back to IDLE on timeout.
  always_comb begin
    state_d = state_q;
    if (key_strobe) begin
      case (state_q)
        ST_IDLE: begin
          if (key_data == SC_EXT)      state_d = ST_E0;
          else if (key_data == SC_BRK) state_d = ST_F0;
          else                         state_d = ST_IDLE;
        end
        ST_E0: begin
          if (key_data == SC_BRK)      state_d = ST_E0F0;
          else if (key_data == SC_EXT) state_d = ST_E0;
          else                         state_d = ST_IDLE;
        end
        default:                       state_d = ST_IDLE;
      endcase
    end else if (timeout) begin
      state_d = ST_IDLE;
    end
  end

  // Event generation: a non-prefix byte completes a sequence in the current state.
  always_comb begin
    evt_push     = 1'b0;
    evt_new.ext  = 1'b0;
    evt_new.brk  = 1'b0;
    evt_new.code = key_data;
    if (key_strobe) begin
      case (state_q)
        ST_IDLE: evt_push = !((key_data == SC_EXT) || (key_data == SC_BRK) ||
                              (key_data == SC_ACK) || (key_data == SC_BAT));
        ST_E0: begin
          evt_push    = !((key_data == SC_EXT) || (key_data == SC_BRK));
          evt_new.ext = 1'b1;
        end
        ST_F0: begin
          evt_push    = 1'b1;
          evt_new.brk = 1'b1;
        end
        default: begin
          evt_push    = 1'b1;
          evt_new.ext = 1'b1;
          evt_new.brk = 1'b1;
        end
      endcase
    end
  end

  // Idle counter for abandoning a stalled prefix; held at zero while IDLE.
  always_comb begin
    if (key_strobe || (state_q == ST_IDLE) || timeout) to_cnt_d = '0;
    else                                               to_cnt_d = to_cnt_q + 1'b1;
  end

  // Timeout counter register.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) to_cnt_q <= '0;
    else         to_cnt_q <= to_cnt_d;
  end

  // Held/dir update: most recent make wins; releasing the steering key falls back by priority.
  always_comb begin
    held_d = held_q;
    dir_d  = dir_q;
    hit    = dir_decode(evt_new, WASD_EN);
    if (evt_push && hit.hit) begin
      if (!evt_new.brk) begin
        held_d[hit.idx] = 1'b1;
        dir_d           = hit.idx;
      end else begin
        held_d[hit.idx] = 1'b0;
        if ((hit.idx == dir_q) && (held_d != '0)) dir_d = first_held(held_d);
      end
    end
  end

  // Held/dir registers; updated even when the FIFO drops the event.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      held_q <= '0;
      dir_q  <= DIR_UP;
    end else begin
      held_q <= held_d;
      dir_q  <= dir_d;
    end
  end

  assign fifo_pop = !fifo_empty && evt.evt_ready;

  // A new drop wins over a simultaneous clear.
  always_comb begin
    overflow_d = (evt_push && fifo_full && !fifo_pop) || (overflow_q && !overflow_clr);
  end

  // Sticky overflow flag.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) overflow_q <= 1'b0;
    else         overflow_q <= overflow_d;
  end

  sync_fifo #(
    .WIDTH (EVT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_evt_fifo (
    .clk_i   (clock),
    .rst_ni  (resetn),
    .push_i  (evt_push),
    .data_i  (evt_new),
    .pop_i   (fifo_pop),
    .data_o  (evt_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign evt.evt_valid = !fifo_empty;
  assign evt.evt_code  = evt_head.code;
  assign evt.evt_ext   = evt_head.ext;
  assign evt.evt_break = evt_head.brk;

  assign overflow  = overflow_q;
  assign held      = held_q;
  assign dir       = dir_q;
  assign dir_valid = |held_q;

endmodule
